// File: rtl/avr2wb_pkg.sv
// Shared constants for the AVR-to-Wishbone control/status register file.
//  - Register offsets relative to the end of the ADRn block (offset A).
//  - CTRL register bit positions.
//  - Reset pulse FSM state encoding.
package avr2wb_pkg;

  localparam int unsigned REL_BE       = 0;
  localparam int unsigned REL_CTRL     = 1;
  localparam int unsigned REL_INT_EN   = 2;
  localparam int unsigned REL_INT_PEND = 3;
  localparam int unsigned REL_INT_TYPE = 4;
  localparam int unsigned REL_ERR_CNT  = 5;

  localparam int unsigned CTRL_RST_STAT = 0;
  localparam int unsigned CTRL_RST_GO   = 1;
  localparam int unsigned CTRL_GIE      = 6;
  localparam int unsigned CTRL_ERR      = 7;

  typedef enum logic [1:0] {
    RST_IDLE  = 2'd0,
    RST_PULSE = 2'd1,
    RST_WAIT  = 2'd2
  } rst_state_t;

  // Absolute register offset given the number of ADRn bytes in front.
  function automatic logic [7:0] reg_off(input int unsigned adr_bytes, input int unsigned rel);
    return 8'(adr_bytes + rel);
  endfunction

endpackage

// File: rtl/avr2wb_int_ch.sv
// One WB interrupt channel: input history flop, rising-edge detect and a
// pending bit with write-one-to-clear.
// Ports: cp2 clock, ireset sync active-high reset, int_in raw WB line,
//        int_type 0=level-high 1=rising edge, clr W1C strobe for this bit,
//        pend pending flag.
module avr2wb_int_ch (
  input  logic cp2,
  input  logic ireset,
  input  logic int_in,
  input  logic int_type,
  input  logic clr,
  output logic pend
);

  logic prev;
  logic set;

  assign set = int_in & (~int_type | ~prev);

  // A new set in the same cycle as a clear wins.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= int_in;
      pend <= set | (pend & ~clr);
    end
  end

endmodule

// File: rtl/rg_md.sv
// Plain writable register with synchronous reset to a parameterised value.
// Ports: cp2 clock, ireset sync active-high reset, we write enable,
//        d write data, q register contents.
module rg_md #(
  parameter int unsigned      P_W   = 8,
  parameter logic [P_W-1:0]   P_RST = '0
) (
  input  logic           cp2,
  input  logic           ireset,
  input  logic           we,
  input  logic [P_W-1:0] d,
  output logic [P_W-1:0] q
);

  always_ff @(posedge cp2) begin
    if (ireset) q <= P_RST;
    else if (we) q <= d;
  end

endmodule

// File: rtl/avr2wb_ctrl_regs_mc.sv
// Control/status register file for the AVR-to-Wishbone bridge.
// Holds WB high address bytes and byte enables, generates a timed WB reset
// pulse, merges P_INT_CH WB interrupt lines into int_o and keeps a sticky
// WB error flag. Mapped in AVR data memory (P_IO_LOC=0) or IO space (1).
// Optional: define AVR2WB_ERR_CNT_EN to add a saturating WB error counter.
// Ports: cp2/ireset clock and sync reset; sel/ramadr/ramre/ramwe DM access;
//        adr/iore/iowe IO access; dbus_in/dbus_out data; io_out_en IO read hit;
//        wb_adr_hi/wb_be/wb_rst_o WB side controls; int_o AVR interrupt;
//        wb_rst_i/wb_int_i/wb_err_i WB status inputs.
//
// Reset FSM:
//   state     | meaning
//   RST_IDLE  | no reset activity, CTRL.b1 write starts a pulse
//   RST_PULSE | wb_rst_o high, down-counter running
//   RST_WAIT  | pulse done, waiting for wb_rst_i to fall
module avr2wb_ctrl_regs_mc
  import avr2wb_pkg::*;
#(
  parameter int unsigned P_IO_LOC    = 0,
  parameter logic [7:0]  P_DM_BASE   = 8'h00,
  parameter logic [5:0]  P_IO_BASE   = 6'h00,
  parameter int unsigned P_ADR_BYTES = 3,
  parameter int unsigned P_INT_CH    = 1,
  parameter int unsigned P_RST_LEN   = 16
) (
  input  logic                     cp2,
  input  logic                     ireset,
  input  logic                     sel,
  input  logic [8:0]               ramadr,
  input  logic                     ramre,
  input  logic                     ramwe,
  input  logic [7:0]               dbus_in,
  output logic [7:0]               dbus_out,
  input  logic [5:0]               adr,
  input  logic                     iore,
  input  logic                     iowe,
  output logic                     io_out_en,
  output logic [8*P_ADR_BYTES-1:0] wb_adr_hi,
  output logic [3:0]               wb_be,
  output logic                     wb_rst_o,
  output logic                     int_o,
  input  logic                     wb_rst_i,
  input  logic [P_INT_CH-1:0]      wb_int_i,
  input  logic                     wb_err_i
);

`ifdef AVR2WB_ERR_CNT_EN
  localparam int unsigned NREG = P_ADR_BYTES + REL_ERR_CNT + 1;
  localparam logic [7:0]  OFF_ERRC = reg_off(P_ADR_BYTES, REL_ERR_CNT);
`else
  localparam int unsigned NREG = P_ADR_BYTES + REL_ERR_CNT;
`endif
  localparam logic [7:0] NREG_B    = 8'(NREG);
  localparam logic [7:0] OFF_BE    = reg_off(P_ADR_BYTES, REL_BE);
  localparam logic [7:0] OFF_CTRL  = reg_off(P_ADR_BYTES, REL_CTRL);
  localparam logic [7:0] OFF_EN    = reg_off(P_ADR_BYTES, REL_INT_EN);
  localparam logic [7:0] OFF_PEND  = reg_off(P_ADR_BYTES, REL_INT_PEND);
  localparam logic [7:0] OFF_TYPE  = reg_off(P_ADR_BYTES, REL_INT_TYPE);
  localparam logic [7:0] RST_LOAD  = 8'(P_RST_LEN - 1);
  localparam bit         IO_MAP    = (P_IO_LOC != 0);

  // Offsets below the base wrap to large values and fall out of range.
  logic [7:0] dm_off, io_off, off;
  logic       in_range, wr_hit, rd_hit;

  assign dm_off    = ramadr[7:0] - P_DM_BASE;
  assign io_off    = {2'b00, adr} - {2'b00, P_IO_BASE};
  assign off       = IO_MAP ? io_off : dm_off;
  assign in_range  = (IO_MAP ? 1'b1 : (sel & ramadr[8])) & (off < NREG_B);
  assign wr_hit    = in_range & (IO_MAP ? iowe : ramwe);
  assign rd_hit    = in_range & (IO_MAP ? iore : ramre);
  assign io_out_en = IO_MAP & rd_hit;

  logic we_be, we_ctrl, we_en, we_pend, we_type;
  assign we_be   = wr_hit & (off == OFF_BE);
  assign we_ctrl = wr_hit & (off == OFF_CTRL);
  assign we_en   = wr_hit & (off == OFF_EN);
  assign we_pend = wr_hit & (off == OFF_PEND);
  assign we_type = wr_hit & (off == OFF_TYPE);

  logic [7:0] adr_q [P_ADR_BYTES];

  for (genvar gi = 0; gi < P_ADR_BYTES; gi++) begin : g_adr
    logic we_adr;
    assign we_adr = wr_hit & (off == 8'(gi));
    rg_md #(.P_W(8), .P_RST(8'h00)) u_adr (
      .cp2(cp2), .ireset(ireset), .we(we_adr), .d(dbus_in), .q(adr_q[gi])
    );
  end

  always_comb begin
    wb_adr_hi = '0;
    for (int i = 0; i < P_ADR_BYTES; i++) wb_adr_hi[8*i +: 8] = adr_q[i];
  end

  rg_md #(.P_W(4), .P_RST(4'hF)) u_be (
    .cp2(cp2), .ireset(ireset), .we(we_be), .d(dbus_in[3:0]), .q(wb_be)
  );

  logic [P_INT_CH-1:0] int_en_q, int_type_q, int_pend;
  logic                gie_q, err_q;

  for (genvar gc = 0; gc < P_INT_CH; gc++) begin : g_ch
    avr2wb_int_ch u_ch (
      .cp2(cp2), .ireset(ireset), .int_in(wb_int_i[gc]), .int_type(int_type_q[gc]),
      .clr(we_pend & dbus_in[gc]), .pend(int_pend[gc])
    );
  end

  // Error set dominates a same-cycle W1C.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      int_en_q   <= '0;
      int_type_q <= '0;
      gie_q      <= 1'b0;
      err_q      <= 1'b0;
      int_o      <= 1'b0;
    end else begin
      if (we_en)   int_en_q   <= dbus_in[P_INT_CH-1:0];
      if (we_type) int_type_q <= dbus_in[P_INT_CH-1:0];
      if (we_ctrl) gie_q      <= dbus_in[CTRL_GIE];
      err_q <= wb_err_i | (err_q & ~(we_ctrl & dbus_in[CTRL_ERR]));
      int_o <= gie_q & |(int_pend & int_en_q);
    end
  end

  rst_state_t rst_state;
  logic [7:0] rst_cnt;

  always_ff @(posedge cp2) begin
    if (ireset) begin
      rst_state <= RST_IDLE;
      rst_cnt   <= 8'd0;
      wb_rst_o  <= 1'b0;
    end else begin
      case (rst_state)
        RST_IDLE: begin
          if (we_ctrl && dbus_in[CTRL_RST_GO]) begin
            rst_state <= RST_PULSE;
            rst_cnt   <= RST_LOAD;
            wb_rst_o  <= 1'b1;
          end
        end
        RST_PULSE: begin
          if (rst_cnt == 8'd0) begin
            rst_state <= RST_WAIT;
            wb_rst_o  <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end
        RST_WAIT: begin
          if (!wb_rst_i) rst_state <= RST_IDLE;
        end
        default: begin
          rst_state <= RST_IDLE;
          wb_rst_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AVR2WB_ERR_CNT_EN
  logic       err_prev, err_rise, we_errc;
  logic [7:0] err_cnt;

  assign err_rise = wb_err_i & ~err_prev;
  assign we_errc  = wr_hit & (off == OFF_ERRC);

  // A write clears the counter but still counts a coincident rising edge.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      err_prev <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      err_prev <= wb_err_i;
      if (we_errc)                          err_cnt <= {7'd0, err_rise};
      else if (err_rise && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < P_ADR_BYTES; i++) begin
      if (off == 8'(i)) rd_data = adr_q[i];
    end
    if (off == OFF_BE) rd_data = {4'h0, wb_be};
    if (off == OFF_CTRL) begin
      rd_data[CTRL_RST_STAT] = wb_rst_i;
      rd_data[CTRL_RST_GO]   = (rst_state != RST_IDLE);
      rd_data[CTRL_GIE]      = gie_q;
      rd_data[CTRL_ERR]      = err_q;
    end
    if (off == OFF_EN)   rd_data = 8'(int_en_q);
    if (off == OFF_PEND) rd_data = 8'(int_pend);
    if (off == OFF_TYPE) rd_data = 8'(int_type_q);
`ifdef AVR2WB_ERR_CNT_EN
    if (off == OFF_ERRC) rd_data = err_cnt;
`endif
  end

  assign dbus_out = rd_hit ? rd_data : 8'h00;

endmodule

// File: tb/tb_avr2wb_ctrl_regs_mc.sv
// Bench for avr2wb_ctrl_regs_mc. Two instances: an IO-mapped one
// (base 6'h10, 1 address byte, 4 interrupt channels, 4-cycle reset pulse)
// and a DM-mapped one (base 8'h20, 3 address bytes).
// Inputs change on the falling edge; outputs are read at/after it.
module tb_avr2wb_ctrl_regs_mc;

  logic cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  logic       ireset, sel, ramre, ramwe, iore, iowe;
  logic [8:0] ramadr;
  logic [5:0] adr;
  logic [7:0] dbus_in;

  logic [7:0]  dout_io, adr_hi_io;
  logic [3:0]  be_io, wbint_io;
  logic        oen_io, rsto_io, into_io, rsti_io, err_io;

  logic [7:0]  dout_dm;
  logic [23:0] adr_hi_dm;
  logic [3:0]  be_dm;
  logic        oen_dm, rsto_dm, into_dm, rsti_dm, err_dm;
  logic [0:0]  wbint_dm;

  int total = 0;
  int bad   = 0;
  int rst_hi = 0;

`ifdef AVR2WB_ERR_CNT_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  avr2wb_ctrl_regs_mc #(
    .P_IO_LOC(1), .P_IO_BASE(6'h10), .P_ADR_BYTES(1), .P_INT_CH(4), .P_RST_LEN(4)
  ) u_io (
    .cp2(cp2), .ireset(ireset), .sel(sel), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dbus_in(dbus_in), .dbus_out(dout_io), .adr(adr), .iore(iore), .iowe(iowe),
    .io_out_en(oen_io), .wb_adr_hi(adr_hi_io), .wb_be(be_io), .wb_rst_o(rsto_io),
    .int_o(into_io), .wb_rst_i(rsti_io), .wb_int_i(wbint_io), .wb_err_i(err_io)
  );

  avr2wb_ctrl_regs_mc #(
    .P_IO_LOC(0), .P_DM_BASE(8'h20), .P_ADR_BYTES(3), .P_INT_CH(1), .P_RST_LEN(16)
  ) u_dm (
    .cp2(cp2), .ireset(ireset), .sel(sel), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dbus_in(dbus_in), .dbus_out(dout_dm), .adr(adr), .iore(iore), .iowe(iowe),
    .io_out_en(oen_dm), .wb_adr_hi(adr_hi_dm), .wb_be(be_dm), .wb_rst_o(rsto_dm),
    .int_o(into_dm), .wb_rst_i(rsti_dm), .wb_int_i(wbint_dm), .wb_err_i(err_dm)
  );

  always @(negedge cp2) if (rsto_io === 1'b1) rst_hi++;

  typedef struct {
    bit         wr;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    bit         hit;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    adr = a; dbus_in = d; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic h);
    adr = a; iore = 1'b1;
    #1;
    d = dout_io; h = oen_io;
    iore = 1'b0;
  endtask

  task automatic dm_wr(input logic [8:0] a, input logic [7:0] d);
    sel = 1'b1; ramadr = a; dbus_in = d; ramwe = 1'b1;
    @(negedge cp2);
    ramwe = 1'b0; sel = 1'b0;
  endtask

  task automatic dm_rd(input logic [8:0] a, output logic [7:0] d);
    sel = 1'b1; ramadr = a; ramre = 1'b1;
    #1;
    d = dout_dm;
    ramre = 1'b0; sel = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       h;
    int         base;

    // wr, adr, wdata, expected read, expected io_out_en
    vecs.push_back('{1'b0, 6'h10, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h11, 8'h00, 8'h0F, 1'b1});
    vecs.push_back('{1'b0, 6'h12, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h13, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h14, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h15, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h16, 8'h00, 8'h00, ERRC});
    vecs.push_back('{1'b0, 6'h17, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h0F, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 6'h10, 8'hA5, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h10, 8'h00, 8'hA5, 1'b1});
    vecs.push_back('{1'b1, 6'h11, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h11, 8'h00, 8'h0F, 1'b1});
    vecs.push_back('{1'b1, 6'h11, 8'h03, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h11, 8'h00, 8'h03, 1'b1});
    vecs.push_back('{1'b1, 6'h13, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h13, 8'h00, 8'h0F, 1'b1});
    vecs.push_back('{1'b1, 6'h15, 8'hF3, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h15, 8'h00, 8'h03, 1'b1});
    vecs.push_back('{1'b1, 6'h12, 8'h40, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h12, 8'h00, 8'h40, 1'b1});
    vecs.push_back('{1'b1, 6'h17, 8'h55, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h17, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 6'h12, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h12, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 6'h13, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 6'h15, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 6'h13, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 6'h15, 8'h00, 8'h00, 1'b1});

    ireset = 1'b1; sel = 1'b0; ramre = 1'b0; ramwe = 1'b0; iore = 1'b0; iowe = 1'b0;
    ramadr = '0; adr = '0; dbus_in = '0;
    rsti_io = 1'b0; err_io = 1'b0; wbint_io = '0;
    rsti_dm = 1'b0; err_dm = 1'b0; wbint_dm = '0;
    repeat (3) @(negedge cp2);
    ireset = 1'b0;

    chk("rst_wb_rst_o_io", rsto_io, 1'b0);
    chk("rst_int_o_io", into_io, 1'b0);
    chk("rst_be_io", be_io, 4'hF);
    chk("rst_wb_rst_o_dm", rsto_dm, 1'b0);
    chk("rst_int_o_dm", into_dm, 1'b0);
    chk("rst_be_dm", be_dm, 4'hF);
    chk("rst_adr_hi_dm", adr_hi_dm, 24'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        io_wr(vecs[i].a, vecs[i].d);
      end else begin
        io_rd(vecs[i].a, d, h);
        chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
        chk($sformatf("vec%0d_hit", i), h, vecs[i].hit);
        @(negedge cp2);
      end
    end
    chk("adr_hi_io", adr_hi_io, 8'hA5);
    chk("be_io", be_io, 4'h3);

    // DM-mapped instance
    dm_wr(9'h120, 8'h12);
    dm_wr(9'h121, 8'h34);
    dm_wr(9'h122, 8'h56);
    chk("dm_adr_hi", adr_hi_dm, 24'h563412);
    dm_rd(9'h120, d); chk("dm_rd_adr0", d, 8'h12);
    dm_rd(9'h121, d); chk("dm_rd_adr1", d, 8'h34);
    dm_rd(9'h122, d); chk("dm_rd_adr2", d, 8'h56);
    @(negedge cp2);
    dm_wr(9'h020, 8'hFF);
    chk("dm_no_bit8", adr_hi_dm, 24'h563412);
    dm_wr(9'h123, 8'h05);
    chk("dm_be", be_dm, 4'h5);
    io_rd(6'h10, d, h);
    chk("dm_io_out_en", oen_dm, 1'b0);
    @(negedge cp2);
    ireset = 1'b1;
    @(negedge cp2);
    ireset = 1'b0;
    chk("dm_rst_adr_hi", adr_hi_dm, 24'h0);
    chk("dm_rst_be", be_dm, 4'hF);

    // Reset pulse: exactly 4 cycles, busy held through WAIT, second start ignored
    base = rst_hi;
    rsti_io = 1'b1;
    io_wr(6'h12, 8'h02);
    chk("rst_pulse_start", rsto_io, 1'b1);
    io_rd(6'h12, d, h); chk("ctrl_busy", d, 8'h03);
    @(negedge cp2);
    io_wr(6'h12, 8'h02);
    repeat (8) @(negedge cp2);
    chk("rst_pulse_len", rst_hi - base, 4);
    io_rd(6'h12, d, h); chk("ctrl_wait_busy", d, 8'h03);
    rsti_io = 1'b0;
    @(negedge cp2);
    io_rd(6'h12, d, h); chk("ctrl_idle", d, 8'h00);
    @(negedge cp2);
    io_wr(6'h12, 8'h02);
    chk("rst_pulse_again", rsto_io, 1'b1);
    ireset = 1'b1;
    @(negedge cp2);
    ireset = 1'b0;
    chk("rst_abort", rsto_io, 1'b0);
    io_rd(6'h12, d, h); chk("ctrl_after_abort", d, 8'h00);
    @(negedge cp2);

    // Interrupts
    io_wr(6'h15, 8'h02);
    io_wr(6'h13, 8'h02);
    io_wr(6'h12, 8'h40);
    wbint_io = 4'b0010;
    @(negedge cp2);
    io_rd(6'h14, d, h); chk("pend_edge", d, 8'h02);
    chk("int_o_lag", into_io, 1'b0);
    @(negedge cp2);
    chk("int_o_set", into_io, 1'b1);
    io_wr(6'h14, 8'h02);
    io_rd(6'h14, d, h); chk("pend_w1c", d, 8'h00);
    chk("int_o_hold", into_io, 1'b1);
    @(negedge cp2);
    chk("int_o_drop", into_io, 1'b0);
    wbint_io = 4'b0011;
    @(negedge cp2);
    io_rd(6'h14, d, h); chk("pend_level", d, 8'h01);
    @(negedge cp2);
    io_wr(6'h14, 8'h01);
    io_rd(6'h14, d, h); chk("pend_set_wins", d, 8'h01);
    chk("int_o_masked", into_io, 1'b0);
    @(negedge cp2);
    io_wr(6'h13, 8'h03);
    chk("int_o_en_lag", into_io, 1'b0);
    @(negedge cp2);
    chk("int_o_en", into_io, 1'b1);
    wbint_io = 4'b0000;
    io_wr(6'h14, 8'h01);
    io_rd(6'h14, d, h); chk("pend_cleared", d, 8'h00);
    @(negedge cp2);

    // Sticky error
    repeat (3) begin
      err_io = 1'b1;
      @(negedge cp2);
      err_io = 1'b0;
      @(negedge cp2);
    end
    io_rd(6'h12, d, h); chk("err_sticky", d, 8'hC0);
    @(negedge cp2);
`ifdef AVR2WB_ERR_CNT_EN
    io_rd(6'h16, d, h); chk("errcnt_3", d, 8'h03);
    @(negedge cp2);
`else
    io_rd(6'h16, d, h); chk("errcnt_absent", d, 8'h00);
    chk("errcnt_no_hit", h, 1'b0);
    @(negedge cp2);
`endif
    err_io = 1'b1;
    io_wr(6'h12, 8'hC0);
    err_io = 1'b0;
    io_rd(6'h12, d, h); chk("err_clear_loses", d, 8'hC0);
    @(negedge cp2);
    io_wr(6'h12, 8'hC0);
    io_rd(6'h12, d, h); chk("err_clear", d, 8'h40);
    @(negedge cp2);
`ifdef AVR2WB_ERR_CNT_EN
    repeat (300) begin
      err_io = 1'b1;
      @(negedge cp2);
      err_io = 1'b0;
      @(negedge cp2);
    end
    io_rd(6'h16, d, h); chk("errcnt_sat", d, 8'hFF);
    @(negedge cp2);
    err_io = 1'b1;
    io_wr(6'h16, 8'h00);
    err_io = 1'b0;
    io_rd(6'h16, d, h); chk("errcnt_wr_inc", d, 8'h01);
    @(negedge cp2);
    io_wr(6'h16, 8'hAA);
    io_rd(6'h16, d, h); chk("errcnt_wr_clr", d, 8'h00);
    chk("errcnt_hit", h, 1'b1);
    @(negedge cp2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
